// File: rtl/pipeline_stall_controller.sv
// Stall/flush control for a 5-stage pipeline: a memory-wait FSM with timeout,
// hazard/branch steering of the front end, and a saturating stall counter.
module pipeline_stall_controller #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_stats,
  output logic             freeze_if,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             freeze_all,
  output logic             mem_start,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, RELEASE} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Memory-access FSM: launch from RUN, wait for ready or timeout, then release.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    freeze_all   = 1'b0;
    mem_start    = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      RUN: begin
        // rst_n gates the launch so no pulse escapes while reset is held.
        if (mem_req && rst_n) begin
          mem_start    = 1'b1;
          freeze_all   = 1'b1;
          wait_cnt_nxt = 4'd0;
          state_nxt    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        freeze_all   = 1'b1;
        wait_cnt_nxt = wait_cnt + 4'd1;
        if (mem_ready) begin
          state_nxt = RELEASE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = RELEASE;
        end
      end
      RELEASE: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Front-end steering: a frozen back end overrides branch, branch overrides hazard.
  always_comb begin
    freeze_if     = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_exe = 1'b0;
    if (freeze_all) begin
      freeze_if = 1'b1;
    end else if (branch_taken) begin
      flush_if_id   = 1'b1;
      bubble_id_exe = 1'b1;
    end else if (hazard_detected) begin
      freeze_if     = 1'b1;
      bubble_id_exe = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= 4'd0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_hit)
        mem_timeout <= 1'b1;
      if (clr_stats)
        stall_count <= '0;
      else if (freeze_if)
        stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: directed scenarios then
// random traffic, checked against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, hazard_detected, branch_taken, mem_req, mem_ready, clr_stats;
  logic             freeze_if, flush_if_id, bubble_id_exe, freeze_all, mem_start, mem_timeout;
  logic [CNT_W-1:0] stall_count;

  pipeline_stall_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hazard_detected(hazard_detected),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .clr_stats(clr_stats), .freeze_if(freeze_if), .flush_if_id(flush_if_id),
    .bubble_id_exe(bubble_id_exe), .freeze_all(freeze_all), .mem_start(mem_start),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit fi, fl, bu, fa, ms, mt;
    int sc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Model state, expressed in terms of the access lifecycle.
  bit m_busy, m_releasing, m_timeout;
  int m_waited, m_count;

  task automatic model_reset();
    m_busy = 0; m_releasing = 0; m_timeout = 0; m_waited = 0; m_count = 0;
  endtask

  task automatic chk(string nm, int c, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("freeze_if",     e.cyc, int'(freeze_if),     int'(e.fi));
      chk("flush_if_id",   e.cyc, int'(flush_if_id),   int'(e.fl));
      chk("bubble_id_exe", e.cyc, int'(bubble_id_exe), int'(e.bu));
      chk("freeze_all",    e.cyc, int'(freeze_all),    int'(e.fa));
      chk("mem_start",     e.cyc, int'(mem_start),     int'(e.ms));
      chk("mem_timeout",   e.cyc, int'(mem_timeout),   int'(e.mt));
      chk("stall_count",   e.cyc, int'(stall_count),   e.sc);
    end
  end

  // One clock cycle: drive inputs, predict this cycle's outputs, then advance the model.
  task automatic cycle(bit h, bit b, bit mr, bit rd, bit clr, bit rn);
    exp_t e;
    bit   launch;
    hazard_detected = h; branch_taken = b; mem_req = mr;
    mem_ready = rd; clr_stats = clr; rst_n = rn;
    if (!rn) model_reset();
    launch = rn && mr && !m_busy && !m_releasing;
    e.cyc = cyc;
    e.ms  = launch;
    e.fa  = launch || m_busy;
    e.fi  = e.fa || (!b && h);
    e.fl  = !e.fa && b;
    e.bu  = !e.fa && (b || h);
    e.mt  = m_timeout;
    e.sc  = m_count;
    q.push_back(e);
    @(posedge clk);
    if (rn) begin
      if (clr) m_count = 0;
      else if (e.fi && m_count < CMAX) m_count++;
      if (launch) begin
        m_busy = 1; m_waited = 0;
      end else if (m_busy) begin
        if (rd) begin
          m_busy = 0; m_releasing = 1;
        end else if (m_waited == TIMEOUT - 1) begin
          m_busy = 0; m_releasing = 1; m_timeout = 1;
        end else begin
          m_waited++;
        end
      end else if (m_releasing) begin
        m_releasing = 0;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    // Reset held with mem_req high: no launch, everything at reset values.
    repeat (3) cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    // Hazard stall for two cycles.
    repeat (2) cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    // Branch wins over hazard.
    cycle(1, 1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    // Memory access with ready at N+3, mem_req still high in RELEASE.
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(1, 1, 1, 1, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    // Minimum latency: ready in the first wait cycle.
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    // Reset in the middle of an access, then relaunch.
    repeat (3) cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    // Timeout: mem_ready never arrives.
    repeat (20) cycle(0, 0, 1, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 0, 1);
    // Timeout and ready coinciding: ready wins (fresh reset first).
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 1);
    repeat (14) cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 1, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 0, 1);
    // Saturation then clear while still stalling.
    cycle(0, 0, 0, 0, 1, 1);
    repeat (20) cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    // Random traffic, alternating between prompt and sluggish memory.
    for (int i = 0; i < 1500; i++) begin
      bit slow;
      slow = ((i / 100) % 2) == 1;
      cycle($urandom_range(3) == 0, $urandom_range(5) == 0, $urandom_range(2) == 0,
            slow ? ($urandom_range(39) == 0) : ($urandom_range(3) == 0),
            $urandom_range(29) == 0, $urandom_range(149) != 0);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
